seq_pattern_gen: RTL

- Serial bit-stream generator; the transmit side of the serial sequence-detection path.
- Shifts a loaded W-bit pattern out MSB-first on a one-bit line X, one bit per clock, repeated a programmable number of times with optional idle gap bits between repeats.
- Flags the final bit of each pattern. This is the cycle where a downstream Mealy detector for that pattern must assert its output, so benches can compare against it directly.
- Uses a start/busy/done handshake to a controller or testbench.

---
 rtl/seq_pattern_gen.sv | 119 +++++++++++
 1 files changed

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a latched W-bit pattern out MSB-first,
// repeated repeat_n times with optional idle gap cycles between repeats.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; all outputs low
// SHIFT | X carries latched_pattern[bit_idx]; last_bit at index 0
// GAP   | idle gap between repeats; busy high, X_valid low
// DONE  | one-cycle done pulse; start accepted as in IDLE
module seq_pattern_gen #(
   parameter int W    = 5,
   parameter int CNTW = 4,
   parameter int GAPW = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [W-1:0]    pattern,
   input  logic [CNTW-1:0] repeat_n,
   input  logic [GAPW-1:0] gap,
   output logic            X,
   output logic            X_valid,
   output logic            last_bit,
   output logic            busy,
   output logic            done
);

   localparam int BW = (W > 1) ? $clog2(W) : 1;
   localparam logic [BW-1:0] IDX_MSB = BW'(W - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

   state_t          state;
   logic [W-1:0]    pat_q;
   logic [CNTW-1:0] rep_cnt;
   logic [GAPW-1:0] gap_q;
   logic [GAPW-1:0] gap_cnt;
   logic [BW-1:0]   bit_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pat_q    <= '0;
         rep_cnt  <= '0;
         gap_q    <= '0;
         gap_cnt  <= '0;
         bit_idx  <= '0;
         X        <= 1'b0;
         X_valid  <= 1'b0;
         last_bit <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         X        <= 1'b0;
         X_valid  <= 1'b0;
         last_bit <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start && (repeat_n != '0)) begin
                  pat_q   <= pattern;
                  rep_cnt <= repeat_n;
                  gap_q   <= gap;
                  bit_idx <= IDX_MSB;
                  X       <= pattern[W-1];
                  X_valid <= 1'b1;
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end else if (start) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            SHIFT: begin
               if (bit_idx != '0) begin
                  bit_idx  <= bit_idx - 1'b1;
                  X        <= pat_q[bit_idx - 1'b1];
                  X_valid  <= 1'b1;
                  last_bit <= (bit_idx == BW'(1));
               end else begin
                  // Final bit of a repetition is on X this cycle.
                  rep_cnt <= rep_cnt - 1'b1;
                  if (rep_cnt == CNTW'(1)) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else if (gap_q != '0) begin
                     gap_cnt <= gap_q - 1'b1;
                     state   <= GAP;
                  end else begin
                     bit_idx <= IDX_MSB;
                     X       <= pat_q[W-1];
                     X_valid <= 1'b1;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == '0) begin
                  bit_idx <= IDX_MSB;
                  X       <= pat_q[W-1];
                  X_valid <= 1'b1;
                  state   <= SHIFT;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
